// File: rtl/psram_qpi_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : psram_qpi_responder_if
// Purpose  : PSRAM bus between controller (master) and responder (slave).
//            The 4-bit SIO bus is carried as separate in/out/enable lanes;
//            the pad ring combines them as mem_sio = oe ? out : 'z.
// Revision : 1.0 - initial release
// ============================================================================
interface psram_qpi_responder_if;
    logic       mem_ce;       // chip enable, active low
    logic [3:0] mem_sio_i;    // SIO value driven by the controller
    logic [3:0] mem_sio_o;    // SIO value driven by the responder
    logic       mem_sio_oe;   // responder owns the SIO bus when high

    modport master (
        output mem_ce,
        output mem_sio_i,
        input  mem_sio_o,
        input  mem_sio_oe
    );

    modport slave (
        input  mem_ce,
        input  mem_sio_i,
        output mem_sio_o,
        output mem_sio_oe
    );
endinterface
`default_nettype wire

// File: rtl/psram_qpi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : psram_qpi_responder
// Purpose  : Memory-side model of a QPI PSRAM. Decodes the SPI init sequence
//            (66h/99h/35h), then serves QPI EBh reads and 38h writes from an
//            internal 16-bit word array. Clocked by the bus clock.
// Revision : 1.0 - initial release
// ============================================================================
module psram_qpi_responder #(
    parameter int ADDR_W    = 8,
    parameter int READ_WAIT = 8
) (
    input  logic                       mem_clk,
    input  logic                       rst_n,
    psram_qpi_responder_if.slave       bus,
    output logic                       qpi_mode,
    output logic                       rsten_armed,
    output logic [7:0]                 last_cmd,
    output logic                       err_pulse
);

    localparam int              KW     = $clog2(READ_WAIT + 9) + 1;
    localparam int              DEPTH  = 2 ** ADDR_W;
    localparam logic [KW-1:0]   K_LAST_HDR = KW'(7);
    localparam logic [KW-1:0]   K_LOAD     = KW'(7 + READ_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SPI_CMD, ST_QPI_CMD, ST_QPI_ADDR,
        ST_WR_DATA, ST_RD_WAIT, ST_RD_DATA, ST_IGNORE
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [6:0]          sh_q, sh_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [11:0]         wd_q, wd_d;
    logic [1:0]          wnib_q, wnib_d;
    logic [11:0]         rword_q, rword_d;
    logic [1:0]          rnib_q, rnib_d;
    logic [3:0]          nib_q, nib_d;
    logic                oe_q, oe_d;
    logic                qpi_q, qpi_d;
    logic                arm_q, arm_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                err_q, err_d;

    logic                w_dec_en;
    logic [7:0]          w_dec_byte;
    logic                w_load;
    logic [ADDR_W-1:0]   w_load_idx;
    logic [15:0]         w_word;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [15:0]         w_wdata;

    logic [15:0]         mem_q [DEPTH];

    // Next-state and datapath decode for one bus clock edge
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        wd_d       = wd_q;
        wnib_d     = wnib_q;
        rword_d    = rword_q;
        rnib_d     = rnib_q;
        nib_d      = nib_q;
        oe_d       = oe_q;
        qpi_d      = qpi_q;
        arm_d      = arm_q;
        cmd_d      = cmd_q;
        err_d      = 1'b0;
        w_dec_en   = 1'b0;
        w_dec_byte = 8'h00;
        w_load     = 1'b0;
        w_load_idx = idx_q;
        w_word     = 16'h0000;
        w_we       = 1'b0;
        w_waddr    = idx_q;
        w_wdata    = {wd_q, bus.mem_sio_i};

        if (bus.mem_ce) begin
            // Deselect always ends the frame, whatever is in flight
            state_d = ST_IDLE;
            k_d     = '0;
            oe_d    = 1'b0;
        end else begin
            if (k_q != {KW{1'b1}}) begin
                k_d = k_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (qpi_q) begin
                        sh_d    = {3'b000, bus.mem_sio_i};
                        state_d = ST_QPI_CMD;
                    end else begin
                        sh_d    = {6'b000000, bus.mem_sio_i[0]};
                        state_d = ST_SPI_CMD;
                    end
                end
                ST_SPI_CMD: begin
                    sh_d = {sh_q[5:0], bus.mem_sio_i[0]};
                    if (k_q == K_LAST_HDR) begin
                        w_dec_en   = 1'b1;
                        w_dec_byte = {sh_q, bus.mem_sio_i[0]};
                        state_d    = ST_IGNORE;
                    end
                end
                ST_QPI_CMD: begin
                    w_dec_en   = 1'b1;
                    w_dec_byte = {sh_q[3:0], bus.mem_sio_i};
                    state_d    = ST_IGNORE;
                end
                ST_QPI_ADDR: begin
                    // Only the low ADDR_W bits of the 24-bit address matter
                    addr_d = ADDR_W'({addr_q, bus.mem_sio_i});
                    if (k_q == K_LAST_HDR) begin
                        idx_d = addr_d;
                        if (cmd_q == 8'h38) begin
                            wnib_d  = 2'd0;
                            state_d = ST_WR_DATA;
                        end else if (READ_WAIT == 0) begin
                            w_load     = 1'b1;
                            w_load_idx = addr_d;
                            state_d    = ST_RD_DATA;
                        end else begin
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
                ST_WR_DATA: begin
                    wd_d   = {wd_q[7:0], bus.mem_sio_i};
                    wnib_d = wnib_q + 1'b1;
                    if (wnib_q == 2'd3) begin
                        w_we  = 1'b1;
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (k_q == K_LOAD) begin
                        w_load  = 1'b1;
                        state_d = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rnib_q == 2'd3) begin
                        w_load = 1'b1;
                    end else begin
                        nib_d   = rword_q[11:8];
                        rword_d = {rword_q[7:0], 4'h0};
                        rnib_d  = rnib_q + 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_dec_en) begin
                cmd_d = w_dec_byte;
                arm_d = 1'b0;
                case (w_dec_byte)
                    8'h66: arm_d = 1'b1;
                    8'h99: begin
                        if (arm_q) qpi_d = 1'b0;
                        else       err_d = 1'b1;
                    end
                    8'h35: begin
                        if (!qpi_q) qpi_d = 1'b1;
                        else        err_d = 1'b1;
                    end
                    8'hF5: begin
                        if (qpi_q) qpi_d = 1'b0;
                        else       err_d = 1'b1;
                    end
                    8'hEB, 8'h38: begin
                        if (qpi_q) state_d = ST_QPI_ADDR;
                        else       err_d   = 1'b1;
                    end
                    default: err_d = 1'b1;
                endcase
            end

            // First nibble of a word goes out one edge ahead of its sample edge
            if (w_load) begin
                w_word  = mem_q[w_load_idx];
                nib_d   = w_word[15:12];
                rword_d = w_word[11:0];
                rnib_d  = 2'd0;
                idx_d   = w_load_idx + 1'b1;
                oe_d    = 1'b1;
            end
        end
    end

    // State register; reset parks in IGNORE so a frame cut by reset is dropped
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IGNORE;
            k_q     <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
            wnib_q  <= '0;
            rword_q <= '0;
            rnib_q  <= '0;
            nib_q   <= '0;
            oe_q    <= 1'b0;
            qpi_q   <= 1'b0;
            arm_q   <= 1'b0;
            cmd_q   <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            wnib_q  <= wnib_d;
            rword_q <= rword_d;
            rnib_q  <= rnib_d;
            nib_q   <= nib_d;
            oe_q    <= oe_d;
            qpi_q   <= qpi_d;
            arm_q   <= arm_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
        end
    end

    // Word array write port; contents survive reset
    always_ff @(posedge mem_clk) begin
        if (w_we) begin
            mem_q[w_waddr] <= w_wdata;
        end
    end

    assign bus.mem_sio_o  = nib_q;
    assign bus.mem_sio_oe = oe_q & ~bus.mem_ce;
    assign qpi_mode       = qpi_q;
    assign rsten_armed    = arm_q;
    assign last_cmd       = cmd_q;
    assign err_pulse      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_qpi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_psram_qpi_responder
// Purpose  : Self-checking bench for psram_qpi_responder: frame table plus
//            read-data scoreboard, and a hand-written mid-read reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_qpi_responder;

    localparam int ADDR_W    = 8;
    localparam int READ_WAIT = 8;
    localparam int DEPTH     = 2 ** ADDR_W;
    localparam int RD_START  = 8 + READ_WAIT;

    typedef enum logic [1:0] {K_SPI, K_QPI, K_WR, K_RD} kind_t;

    typedef struct {
        kind_t       kind;
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          cnt;       // data nibbles (write) or words (read)
        logic [63:0] data;      // up to four write words, first word in MSBs
        logic        exp_qpi;
        logic        exp_arm;
        logic [7:0]  exp_last;
        int          exp_err;   // -1 = not checked
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        qpi_mode;
    logic        rsten_armed;
    logic [7:0]  last_cmd;
    logic        err_pulse;

    int          errors;
    int          checks;
    int          err_seen;
    logic [15:0] mdl [DEPTH];
    logic [3:0]  exp_q [$];
    vec_t        tbl  [19];
    vec_t        tbl2 [3];

    psram_qpi_responder_if bus_if ();

    psram_qpi_responder #(
        .ADDR_W    (ADDR_W),
        .READ_WAIT (READ_WAIT)
    ) dut (
        .mem_clk     (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .qpi_mode    (qpi_mode),
        .rsten_armed (rsten_armed),
        .last_cmd    (last_cmd),
        .err_pulse   (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input kind_t kind, input logic [7:0] cmd, input logic [23:0] addr,
                                input int cnt, input logic [63:0] data, input logic eq,
                                input logic ea, input logic [7:0] el, input int ee);
        vec_t v;
        v.kind = kind; v.cmd = cmd; v.addr = addr; v.cnt = cnt; v.data = data;
        v.exp_qpi = eq; v.exp_arm = ea; v.exp_last = el; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic [3:0] frame_nib(input vec_t v, input int k);
        logic [3:0] r;
        r = 4'($urandom);
        if (v.kind == K_SPI) begin
            if (k < 8) r[0] = v.cmd[7-k];
        end else if (k == 0) begin
            r = v.cmd[7:4];
        end else if (k == 1) begin
            r = v.cmd[3:0];
        end else if (k < 8) begin
            r = v.addr[23-4*(k-2) -: 4];
        end else if (v.kind == K_WR) begin
            r = v.data[63-4*(k-8) -: 4];
        end
        return r;
    endfunction

    // Sample the bus just before edge k: bus ownership and, inside the read
    // window, the nibble the scoreboard expects.
    task automatic sample_bus(input logic exp_oe, input string tag);
        if (err_pulse) err_seen++;
        check({tag, " oe"}, 32'(bus_if.mem_sio_oe), 32'(exp_oe));
        if (exp_oe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s data: got %0h required nothing (scoreboard empty)", tag, bus_if.mem_sio_o);
            end else begin
                check({tag, " data"}, 32'(bus_if.mem_sio_o), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (err_pulse) err_seen++;
            bus_if.mem_ce    = 1'b1;
            bus_if.mem_sio_i = 4'($urandom);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int nclk;
        int rd_from;
        int idx;
        err_seen = 0;
        idx      = int'(v.addr[ADDR_W-1:0]);
        rd_from  = 1 << 30;
        case (v.kind)
            K_WR: begin
                nclk = 8 + v.cnt;
                for (int g = 0; g < v.cnt / 4; g++)
                    mdl[(idx + g) % DEPTH] = v.data[63-16*g -: 16];
            end
            K_RD: begin
                nclk    = RD_START + 4 * v.cnt;
                rd_from = RD_START;
                for (int w = 0; w < v.cnt; w++)
                    for (int n = 0; n < 4; n++)
                        exp_q.push_back(mdl[(idx + w) % DEPTH][15-4*n -: 4]);
            end
            default: nclk = 10;
        endcase
        for (int k = 0; k < nclk; k++) begin
            @(negedge clk);
            sample_bus(k >= rd_from, $sformatf("%s k%0d", name, k));
            bus_if.mem_ce    = 1'b0;
            bus_if.mem_sio_i = frame_nib(v, k);
        end
        @(negedge clk);
        if (err_pulse) err_seen++;
        bus_if.mem_ce = 1'b1;
        #1;
        check({name, " release"}, 32'(bus_if.mem_sio_oe), 32'd0);
        idle(2);
        #1;
        check({name, " qpi_mode"}, 32'(qpi_mode), 32'(v.exp_qpi));
        check({name, " rsten_armed"}, 32'(rsten_armed), 32'(v.exp_arm));
        check({name, " last_cmd"}, 32'(last_cmd), 32'(v.exp_last));
        if (v.exp_err >= 0) check({name, " err_pulses"}, 32'(err_seen), 32'(v.exp_err));
    endtask

    initial begin
        vec_t rv;
        errors = 0;
        checks = 0;

        //          kind   cmd    addr        cnt data                   qpi arm last  err
        tbl[0]  = mk(K_SPI, 8'h66, 24'h000000, 0, 64'h0,                 0, 1, 8'h66, 0);
        tbl[1]  = mk(K_SPI, 8'h99, 24'h000000, 0, 64'h0,                 0, 0, 8'h99, 0);
        tbl[2]  = mk(K_SPI, 8'h35, 24'h000000, 0, 64'h0,                 1, 0, 8'h35, 0);
        tbl[3]  = mk(K_WR,  8'h38, 24'h000005, 4, 64'hA5C3_0000_0000_0000, 1, 0, 8'h38, 0);
        tbl[4]  = mk(K_RD,  8'hEB, 24'h000005, 1, 64'h0,                 1, 0, 8'hEB, 0);
        tbl[5]  = mk(K_WR,  8'h38, 24'h0000FF, 16, 64'h1234_5678_9ABC_DEF0, 1, 0, 8'h38, 0);
        tbl[6]  = mk(K_RD,  8'hEB, 24'h0000FF, 4, 64'h0,                 1, 0, 8'hEB, 0);
        tbl[7]  = mk(K_WR,  8'h38, 24'h000010, 4, 64'hBEEF_0000_0000_0000, 1, 0, 8'h38, 0);
        tbl[8]  = mk(K_WR,  8'h38, 24'h000010, 3, 64'h0120_0000_0000_0000, 1, 0, 8'h38, 0);
        tbl[9]  = mk(K_RD,  8'hEB, 24'h000010, 1, 64'h0,                 1, 0, 8'hEB, 0);
        tbl[10] = mk(K_QPI, 8'h12, 24'h000000, 0, 64'h0,                 1, 0, 8'h12, 1);
        tbl[11] = mk(K_QPI, 8'h99, 24'h000000, 0, 64'h0,                 1, 0, 8'h99, -1);
        tbl[12] = mk(K_QPI, 8'h66, 24'h000000, 0, 64'h0,                 1, 1, 8'h66, 0);
        tbl[13] = mk(K_QPI, 8'h99, 24'h000000, 0, 64'h0,                 0, 0, 8'h99, 0);
        tbl[14] = mk(K_SPI, 8'h35, 24'h000000, 0, 64'h0,                 1, 0, 8'h35, 0);
        tbl[15] = mk(K_RD,  8'hEB, 24'h000001, 2, 64'h0,                 1, 0, 8'hEB, 0);
        tbl[16] = mk(K_QPI, 8'h35, 24'h000000, 0, 64'h0,                 1, 0, 8'h35, 1);
        tbl[17] = mk(K_QPI, 8'hF5, 24'h000000, 0, 64'h0,                 0, 0, 8'hF5, 0);
        tbl[18] = mk(K_SPI, 8'h35, 24'h000000, 0, 64'h0,                 1, 0, 8'h35, 0);

        tbl2[0] = mk(K_SPI, 8'h35, 24'h000000, 0, 64'h0,                 1, 0, 8'h35, 0);
        tbl2[1] = mk(K_RD,  8'hEB, 24'h000005, 1, 64'h0,                 1, 0, 8'hEB, 0);
        tbl2[2] = mk(K_RD,  8'hEB, 24'h0000FF, 4, 64'h0,                 1, 0, 8'hEB, 0);

        rst_n            = 1'b0;
        bus_if.mem_ce    = 1'b1;
        bus_if.mem_sio_i = 4'h0;
        #1;
        check("reset qpi_mode", 32'(qpi_mode), 32'd0);
        check("reset rsten_armed", 32'(rsten_armed), 32'd0);
        check("reset last_cmd", 32'(last_cmd), 32'd0);
        check("reset err_pulse", 32'(err_pulse), 32'd0);
        check("reset oe", 32'(bus_if.mem_sio_oe), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted just before read edge k=17 of a read of word 05h
        rv = tbl[4];
        exp_q.push_back(mdl[5][15:12]);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            sample_bus(k >= RD_START, $sformatf("rstrd k%0d", k));
            bus_if.mem_ce    = 1'b0;
            bus_if.mem_sio_i = frame_nib(rv, k);
        end
        @(negedge clk);
        check("rstrd oe before reset", 32'(bus_if.mem_sio_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstrd oe at reset", 32'(bus_if.mem_sio_oe), 32'd0);
        check("rstrd qpi_mode", 32'(qpi_mode), 32'd0);
        check("rstrd rsten_armed", 32'(rsten_armed), 32'd0);
        check("rstrd last_cmd", 32'(last_cmd), 32'd0);
        check("rstrd err_pulse", 32'(err_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rstrd tail%0d oe", k), 32'(bus_if.mem_sio_oe), 32'd0);
            check($sformatf("rstrd tail%0d err", k), 32'(err_pulse), 32'd0);
            bus_if.mem_sio_i = 4'($urandom);
        end
        idle(2);

        for (int i = 0; i < 3; i++) run_vec(tbl2[i], $sformatf("post%0d", i));

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psram_qpi_responder.md
# psram_qpi_responder

Synthesizable responder model of the QPI PSRAM device, i.e. the memory end of the PSRAM bus that the PSRAM controller drives. It decodes the SPI-mode init sequence (reset-enable, reset, enter-QPI), then serves QPI quad-read (EBh) and quad-write (38h) frames from an internal word array. It is used in loopback builds and benches to close the controller's bus without a physical PSRAM. All logic is clocked by the bus clock.

## Interface
- ADDR_W, 8: word-array index width; depth is 2^ADDR_W 16-bit words.
- READ_WAIT, 8: wait cycles between the last address nibble and the first read-data nibble.
- mem_clk  input  1  bus clock from controller; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_ce  input  1  chip enable, active low; frame boundary.
- mem_sio  inout  4  data bus; driven only during the read-data phase.
- qpi_mode  output  1  1 = device in QPI mode.
- rsten_armed  output  1  reset-enable (66h) accepted, awaiting 99h.
- last_cmd  output  8  last fully received command byte.
- err_pulse  output  1  one-cycle pulse on unsupported command.

## Operation
- Reset values: qpi_mode=0, rsten_armed=0, last_cmd=00h, err_pulse=0, bus released (Z), frame counter k=0. The word array is not cleared by reset.
- Frame: any rising edge with mem_ce=0 is posedge k of the frame, with k starting at 0. Any rising edge with mem_ce=1 returns the block to IDLE and sets k=0.
- States: IDLE, SPI_CMD, QPI_CMD, QPI_ADDR, WR_DATA, RD_WAIT, RD_DATA, IGNORE.
- SPI mode (qpi_mode=0): mem_sio[0] is sampled at k=0..7, MSB first. At k=7 the byte is decoded:
  - 66h: rsten_armed=1.
  - 99h with rsten_armed=1: qpi_mode=0, rsten_armed=0.
  - 35h: qpi_mode=1, rsten_armed=0.
  - any other byte: rsten_armed=0 and err_pulse is asserted.
  - Clocks after k=7 go to IGNORE.
  - mem_sio[3:1] is don't-care and is never driven.
- QPI mode command: the command nibble is taken at k=0 (high) and k=1 (low).
  - 66h and 99h behave as in SPI mode; 99h additionally returns qpi_mode=0.
  - F5h sets qpi_mode=0.
  - EBh and 38h enter QPI_ADDR.
  - Anything else: err_pulse, then IGNORE.
- Address: six nibbles at k=2..7, MSB first, forming a 24-bit value. The word index is bits [ADDR_W-1:0] of that value.
- Write (38h): data nibbles at k=8,9,10,11, MSB first, assemble one 16-bit word.
  - The word is committed to the array on the nibble-3 edge.
  - The index then increments modulo 2^ADDR_W and each further group of 4 nibbles writes the next word (burst).
  - If mem_ce rises before the 4th nibble of a group, that partial word is discarded.
- Read (EBh):
  - RD_WAIT lasts READ_WAIT cycles.
  - Nibbles of word[index] must be valid at posedges k = 8+READ_WAIT+n, n = 0..3, MSB first.
  - Bursting continues with index+1, wrapping modulo depth.
- last_cmd updates on the decode edge (k=7 in SPI mode, k=1 in QPI mode).

## Timing
- Output nibble register: loaded on posedge k-1 so it is stable across posedge k. The controller samples at posedge k.
- Output enable: oe = oe_reg & ~mem_ce, combinational on mem_ce. The bus releases immediately when mem_ce rises, with no clock needed.
- oe_reg sets on posedge 7+READ_WAIT of a read frame and clears on exit from RD_DATA.
- With the default READ_WAIT=8, data is valid at k=16..19, matching the controller's sampling window.
- Write latency: the word is readable by any frame that starts after the commit edge.
- err_pulse is high for exactly one mem_clk cycle. last_cmd and qpi_mode change on the decode edge.
- rst_n low mid-frame: the bus is released at once and all state returns to reset values. The remainder of that frame is ignored until mem_ce is seen high.
- Simultaneous events:
  - A mem_ce=1 edge always wins over decode.
  - A 35h frame received in QPI mode is an unsupported command.

## Test plan
- Init sequence: SPI 66h, 99h, 35h, each as a 10-clock frame -> qpi_mode=1 after the third frame, rsten_armed 1 then 0, no err_pulse.
- Write then read:
  - QPI 38h, address 000005h, data A5C3h, then EBh at 000005h.
  - Required: nibbles A,5,C,3 on mem_sio at k=16..19.
  - Bus must be Z at k<=15 and after mem_ce rises.
- Burst and wrap (ADDR_W=8): write 4 words starting at index FFh -> words land at FFh, 00h, 01h, 02h; a burst read from FFh returns them in the same order.
- Partial write: 38h at 000010h with only 3 data nibbles, then mem_ce high -> word 10h keeps its previous value.
- Errors and abort:
  - QPI command 12h -> err_pulse for one cycle, bus never driven.
  - 99h without a preceding 66h -> qpi_mode stays 1.
  - 66h then 99h -> qpi_mode=0.
- Reset mid-read: assert rst_n low at k=17 -> mem_sio is Z in the same cycle and all outputs return to reset values. Array contents are preserved, as checked by a re-read after re-init.
